// File: rtl/codificacion_dato.sv
// Frame encoder for the validation link: packs a smoke flag and a current-level
// code into a sync/parity/stop frame, holds it HOLD cycles, then idles GAP cycles.
module codificacion_dato #(
  parameter int N    = 8,
  parameter int R    = 3,
  parameter int HOLD = 4,
  parameter int GAP  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [R-1:0] corriente_in,
  input  logic         humo_in,
  input  logic         send,
  input  logic         auto_en,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD);
  localparam logic [3:0] GAP_CNT  = 4'(GAP);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] frame_q;
  logic [R:0]   last_val_q;
  logic         pending_q;

  logic [R:0]   cur_val;
  logic         auto_change;
  logic         req_now;
  logic         start;

  // Frame: sync 2'b10, humo, corriente, even parity over the payload, stop bit.
  function automatic logic [N-1:0] encode(input logic [R:0] v);
    return {2'b10, v, ^v, 1'b1};
  endfunction

  assign cur_val     = {humo_in, corriente_in};
  assign auto_change = auto_en && (cur_val != last_val_q);
  assign req_now     = send || auto_change;
  assign start       = (state_q == S_IDLE) && (req_now || pending_q);

  // NOTE: state is updated with non-blocking assignments and the reset is
  // asynchronous, so every register clears the instant reset falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          cnt_d   = HOLD_CNT;
        end
      end
      S_SEND: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_GAP;
          cnt_d   = GAP_CNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_SEND: begin
        data_out   = frame_q;
        data_valid = 1'b1;
        busy       = 1'b1;
      end
      S_GAP: begin
        busy = 1'b1;
        done = (cnt_q <= 4'd1);
      end
      default: ;
    endcase
  end

  // Inputs are sampled when the frame starts, not when the request arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q    <= '0;
      last_val_q <= '0;
    end else if (start) begin
      frame_q    <= encode(cur_val);
      last_val_q <= cur_val;
    end
  end

  // One-deep pending flag; requests while busy are merged into it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
    end else if (start) begin
      pending_q <= 1'b0;
    end else if ((state_q != S_IDLE) && req_now) begin
      pending_q <= 1'b1;
    end
  end

endmodule
